// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Contents: FSM state enum, datapath widths, the canonical NOP encoding
// for decode, and the (instr, pc) entry carried by the instruction buffer.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    // addi x0, x0, 0 -- decode may substitute this for squashed slots
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of fetch_entry_t.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   flush      - drop every entry (dominates push and pop)
//   push       - write push_data at the tail
//   push_data  - entry to write
//   pop        - advance the head
//   head       - entry at the head, read from registered storage
//   count      - number of valid entries, 0..FIFO_DEPTH
// A push and a pop may coincide on a full buffer; the slot being written
// is the one being released, so the old head is still read out this cycle.
module fetch_fifo import fetch_pkg::*; #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               push,
    input  fetch_entry_t                       push_data,
    input  logic                               pop,
    output fetch_entry_t                       head,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_entry_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;

    // Next pointer and occupancy; pointers wrap naturally (power-of-two depth)
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = {PTR_W{1'b0}};
            wr_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless while count is zero, so no reset
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// In-order instruction fetch stage in front of a zero-latency icache.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   imem_addr       - byte address to icache (the PC register)
//   imem_data       - icache word for imem_addr, same cycle
//   redirect_valid  - execute requests a PC change
//   redirect_pc     - redirect target (low two bits ignored)
//   out_valid       - buffer head holds an instruction
//   out_ready       - decode accepts the head
//   out_instr       - head instruction, zero when out_valid is low
//   out_pc          - head PC, zero when out_valid is low
//   halted          - fetch stopped until redirect or reset
module fetch_stage import fetch_pkg::*; #(
    parameter logic [ADDR_W-1:0] RESET_PC     = 32'h0000_0000,
    parameter int                MEM_DEP      = 64,
    parameter int                FIFO_DEPTH   = 2,
    parameter bit                HALT_ON_ZERO = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               halted
);

    localparam int          CNT_W     = $clog2(FIFO_DEPTH + 1);
    // One bit wider than the PC so the bound cannot overflow
    localparam logic [32:0] MEM_BYTES = 33'(MEM_DEP) << 2;

    fetch_state_t        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                push_s, pop_s, flush_s, can_push_s, halt_cond_s;
    fetch_entry_t        head_s;
    logic [CNT_W-1:0]    count_s;

    assign halt_cond_s = ({1'b0, pc_q} >= MEM_BYTES) ||
                         (HALT_ON_ZERO && (imem_data == 32'h0000_0000));
    // A simultaneous pop frees the slot the push will fill
    assign can_push_s  = (count_s < CNT_W'(FIFO_DEPTH)) || (out_valid && out_ready);

    // State and PC registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state and PC; redirect overrides everything below reset
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_valid) begin
            state_d = FETCH;
            pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    if (halt_cond_s) begin
                        state_d = HALT;
                    end else if (can_push_s) begin
                        pc_d = pc_q + 32'd4;
                    end else begin
                        pc_d = pc_q;
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Buffer control and status outputs
    always_comb begin
        flush_s = redirect_valid;
        pop_s   = out_valid && out_ready && !redirect_valid;
        push_s  = (state_q == FETCH) && !redirect_valid && !halt_cond_s && can_push_s;
        halted  = (state_q == HALT);
    end

    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_s),
        .push      (push_s),
        .push_data ('{instr: imem_data, pc: pc_q}),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s)
    );

    assign imem_addr = pc_q;
    assign out_valid = (count_s != {CNT_W{1'b0}});
    assign out_instr = out_valid ? head_s.instr : 32'h0000_0000;
    assign out_pc    = out_valid ? head_s.pc    : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run scored against the stream of (word, pc) pairs the program implies.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, redirect_valid, out_ready, out_valid, halted;
    logic [31:0] imem_addr, imem_data, redirect_pc, out_instr, out_pc;
    logic        rst_s, redirect_valid_s, out_ready_s, out_valid_s, halted_s;
    logic [31:0] imem_addr_s, imem_data_s, redirect_pc_s, out_instr_s, out_pc_s;

    logic [31:0] mem   [0:63];
    logic [31:0] mem_s [0:3];
    logic [63:0] exp_q [$];
    int          n_chk = 0;
    int          n_fail = 0;

    assign imem_data   = mem[imem_addr[7:2]];
    assign imem_data_s = mem_s[imem_addr_s[3:2]];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .halted(halted)
    );

    fetch_stage #(.MEM_DEP(4)) dut_small (
        .clk(clk), .rst(rst_s), .imem_addr(imem_addr_s), .imem_data(imem_data_s),
        .redirect_valid(redirect_valid_s), .redirect_pc(redirect_pc_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s), .out_instr(out_instr_s),
        .out_pc(out_pc_s), .halted(halted_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected decode-visible stream from a start PC: consecutive words
    // until a zero word or the end of the 64-word memory.
    function automatic void build_stream(input logic [31:0] start);
        exp_q.delete();
        for (longint p = longint'(start); p < 256; p += 4) begin
            if (mem[p / 4] == 32'h0) break;
            exp_q.push_back({mem[p / 4], 32'(p)});
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
        n_chk++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", imem_addr); end
        n_chk++; if (out_instr !== 32'h0 || out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_outs got %h/%h want 0/0", out_instr, out_pc); end
    endtask

    task automatic test_program();
        logic [31:0] words [4];
        words = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0};
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        for (int i = 0; i < 4; i++) mem[i] = words[i];
        out_ready = 1'b1;
        do_reset();
        tick();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL prog_latency1 got %b want 0", out_valid); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++;
            if (out_valid !== 1'b1 || out_instr !== words[k] || out_pc !== 32'(4 * k)) begin
                n_fail++;
                $display("FAIL prog_out%0d got v=%b %h@%h want 1 %h@%h", k, out_valid, out_instr, out_pc, words[k], 32'(4 * k));
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++;
            if (halted !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'd12) begin
                n_fail++;
                $display("FAIL prog_halt got h=%b v=%b pc=%h want 1 0 0000000c", halted, out_valid, imem_addr);
            end
        end
    endtask

    task automatic test_redirect_halt();
        out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h4;
        tick();
        redirect_valid = 1'b0;
        n_chk++; if (halted !== 1'b0 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL rdh_resume got h=%b pc=%h want 0 4", halted, imem_addr); end
        tick();
        n_chk++;
        if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instr !== 32'h00A00113) begin
            n_fail++; $display("FAIL rdh_out got v=%b %h@%h want 1 00a00113@4", out_valid, out_instr, out_pc);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
        out_ready = 1'b0;
        do_reset();
        repeat (5) tick();
        n_chk++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || imem_addr !== 32'h8) begin
            n_fail++; $display("FAIL bp_full got v=%b head=%h pc=%h want 1 0 8", out_valid, out_pc, imem_addr);
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_chk++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== mem[k]) begin
                n_fail++; $display("FAIL bp_order%0d got v=%b %h@%h want 1 %h@%h", k, out_valid, out_instr, out_pc, mem[k], 32'(4 * k));
            end
        end
    endtask

    task automatic test_redirect_full();
        out_ready = 1'b0;
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h1E;
        tick();
        redirect_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b0 || imem_addr !== 32'h1C) begin n_fail++; $display("FAIL rdf_flush got v=%b pc=%h want 0 1c", out_valid, imem_addr); end
        tick();
        n_chk++;
        if (out_valid !== 1'b1 || out_pc !== 32'h1C || out_instr !== mem[7]) begin
            n_fail++; $display("FAIL rdf_head got v=%b %h@%h want 1 %h@1c", out_valid, out_instr, out_pc, mem[7]);
        end
    endtask

    task automatic test_reset_redirect();
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        rst = 1'b0; redirect_valid = 1'b0;
        n_chk++; if (imem_addr !== 32'h0 || out_valid !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL rr_state got pc=%h v=%b h=%b want 0 0 0", imem_addr, out_valid, halted); end
        tick();
        n_chk++; if (out_valid !== 1'b0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rr_idle got v=%b pc=%h want 0 0", out_valid, imem_addr); end
        tick();
        n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_fail++; $display("FAIL rr_first got v=%b pc=%h want 1 0", out_valid, out_pc); end
    endtask

    task automatic test_runoff();
        for (int i = 0; i < 4; i++) mem_s[i] = 32'hA000_0001 + 32'(i);
        out_ready_s = 1'b1; redirect_valid_s = 1'b0; redirect_pc_s = 32'h0;
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            n_chk++;
            if (out_valid_s !== 1'b1 || out_pc_s !== 32'(4 * k) || out_instr_s !== mem_s[k]) begin
                n_fail++; $display("FAIL runoff_out%0d got v=%b %h@%h want 1 %h@%h", k, out_valid_s, out_instr_s, out_pc_s, mem_s[k], 32'(4 * k));
            end
        end
        tick();
        n_chk++;
        if (halted_s !== 1'b1 || imem_addr_s !== 32'd16 || out_valid_s !== 1'b0) begin
            n_fail++; $display("FAIL runoff_halt got h=%b pc=%h v=%b want 1 10 0", halted_s, imem_addr_s, out_valid_s);
        end
        rst_s = 1'b1;
    endtask

    // One observation cycle of the randomized run against the stream model
    task automatic observe(input logic redir, input logic prev_redir);
        if (prev_redir) begin
            n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_flush got v=%b want 0", out_valid); end
        end
        if (!out_valid) begin
            n_chk++; if (out_instr !== 32'h0 || out_pc !== 32'h0) begin n_fail++; $display("FAIL rnd_idle_outs got %h/%h want 0/0", out_instr, out_pc); end
        end
        if (!redir && out_valid && out_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL rnd_extra got %h@%h want no output", out_instr, out_pc);
            end else begin
                if ({out_instr, out_pc} !== exp_q[0]) begin
                    n_fail++; $display("FAIL rnd_data got %h@%h want %h@%h", out_instr, out_pc, exp_q[0][63:32], exp_q[0][31:0]);
                end
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic test_random();
        logic redir, prev;
        for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
        do_reset();
        build_stream(32'h0);
        prev = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            out_ready      = ($urandom_range(0, 9) < 7);
            redir          = ($urandom_range(0, 39) == 0);
            redirect_valid = redir;
            redirect_pc    = 32'($urandom_range(0, 32'h11F));
            observe(redir, prev);
            tick();
            if (redir) build_stream({redirect_pc[31:2], 2'b00});
            prev = redir;
        end
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 150; c++) begin
            observe(1'b0, prev);
            tick();
            prev = 1'b0;
        end
        n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_drain got %0d left want 0", exp_q.size()); end
        n_chk++; if (halted !== 1'b1) begin n_fail++; $display("FAIL rnd_halted got %b want 1", halted); end
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        rst_s = 1'b1; redirect_valid_s = 1'b0; redirect_pc_s = 32'h0; out_ready_s = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        for (int i = 0; i < 4; i++) mem_s[i] = 32'h0;
        test_reset();
        test_program();
        test_redirect_halt();
        test_backpressure();
        test_redirect_full();
        test_reset_redirect();
        test_runoff();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- In-order instruction fetch stage, directly upstream of the combinational zero-latency instruction memory (icache); consumes its read data.
- Holds the PC, drives the memory address and captures the returned word together with its PC.
- Buffers fetched instructions in a small FIFO that feeds decode over a valid/ready handshake.
- Handles redirects from execute, and halts fetch on a zero word or an out-of-range PC.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- MEM_DEP, 64: instruction memory depth in words; valid byte addresses are 0 to MEM_DEP*4-4.
- FIFO_DEPTH, 2: instruction buffer entries; power of two, at least 2.
- HALT_ON_ZERO, 1: when 1, a fetched word of 32'h0 stops fetch.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  32  byte address to the icache; equals the PC register, combinational from state.
- imem_data  in  32  icache read data for imem_addr, valid in the same cycle.
- redirect_valid  in  1  execute requests a PC change (taken branch or jump).
- redirect_pc  in  32  redirect target; bits [1:0] are forced to 0.
- out_valid  out  1  FIFO head holds an instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  head instruction; 32'h0 when out_valid=0.
- out_pc  out  32  PC of the head instruction; 32'h0 when out_valid=0.
- halted  out  1  fetch is stopped (FSM in HALT).

Behaviour:
- FSM states are IDLE, FETCH and HALT.
- Reset: state=IDLE, pc=RESET_PC, FIFO empty, out_valid=0, halted=0.
- IDLE -> FETCH after one cycle, with no push. The first out_valid is therefore 2 cycles after rst deasserts.
- can_push = (count < FIFO_DEPTH) || (out_valid && out_ready). A pop and a push in the same cycle on a full FIFO is allowed.
- FETCH with can_push and no halt condition:
  - push {imem_data, pc};
  - pc <= pc + 4, with 32-bit wrap and no carry-out.
- FETCH without can_push: pc held, no push, no stall bubble lost.
- Halt condition, checked in FETCH before the push, on the current pc/imem_data:
  - pc >= MEM_DEP*4, or (HALT_ON_ZERO && imem_data == 0);
  - effect: no push, pc held, state <= HALT.
  - The halt check does not depend on can_push.
- HALT: no pushes and halted=1. The FIFO keeps draining normally. Only a redirect or reset leaves HALT.
- Redirect has top priority in every state except reset:
  - FIFO is flushed (count=0);
  - pc <= {redirect_pc[31:2], 2'b00};
  - state <= FETCH;
  - no push that cycle;
  - any pop offered that cycle is discarded, so decode must not rely on the handshake when redirect_valid=1.
  - The outputs show the flush on the next cycle (out_valid=0).
- Pop: when out_valid && out_ready, the head advances. FIFO pointers wrap modulo FIFO_DEPTH and count is 0..FIFO_DEPTH.
- out_valid, out_instr and out_pc are driven from registered FIFO state, with no combinational path from out_ready.
- imem_addr depends only on the pc register, with no combinational path from any input.
- Reset asserted mid-operation: everything returns to reset values on the next edge. Reset dominates redirect.

Decomposition:
- Package fetch_pkg: fetch_state_t enum (IDLE, FETCH, HALT); INSTR_W=32; ADDR_W=32; NOP=32'h0000_0013 for decode use; a fetch_entry_t struct {instr, pc}.
- Sub-module fetch_fifo (sync FIFO of fetch_entry_t):
  - ports: clk, rst, flush, push, push_data, pop, head, count;
  - parameter FIFO_DEPTH.
- fetch_stage holds the PC, the FSM and the halt/redirect logic.

Test Plan:
- Reset then out_ready=1, memory holding words 0x00500093, 0x00A00113, 0x002081B3, 0 at addresses 0/4/8/12:
  - out_valid rises 2 cycles after reset release;
  - (instr,pc) = (0x00500093,0), (0x00A00113,4), (0x002081B3,8);
  - then halted=1 with pc stuck at 12 and no 4th output.
- Backpressure with out_ready=0 for 5 cycles:
  - count saturates at 2 and pc stops at RESET_PC+8;
  - on out_ready=1, outputs continue in order with no gap or duplicate.
- Redirect while FIFO is full, redirect_pc=0x1E:
  - next cycle out_valid=0 and imem_addr=0x1C;
  - the following cycle out_pc=0x1C.
- Redirect while halted, to 0x4: halted=0 next cycle and fetch resumes from 0x4.
- Run off the end with MEM_DEP=4 and all words nonzero: after pc=12 is pushed, halted=1 with pc=16.
- Redirect and rst asserted together: the reset state wins, pc=RESET_PC and state=IDLE.
